nwr_segmenter: RTL and testbench
================================

NWR_SEGMENTER -- requirements
Module: nwr_segmenter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, stream data width in bits; legal values 32, 64, 128.
REQ-002 SHALL have parameter LEN_WIDTH, default 20, transfer length width in bytes.
REQ-003 SHALL have parameter ADDR_WIDTH, default 34, RapidIO target address width.
REQ-004 SHALL have parameter MAX_PKT_BYTES, default 256, maximum NWRITE payload per packet; power of two, a multiple of DATA_WIDTH/8, at most 256.
REQ-005 SHALL have the following ports, one per line as name, direction, width, meaning:
  log_clk  in  1  sole clock, rising edge.
  log_rst  in  1  reset, synchronous, active-high.
  xfer_valid_in  in  1  transfer request.
  xfer_ready_o  out  1  block can accept a transfer.
  xfer_addr_in  in  ADDR_WIDTH  start address.
  xfer_len_in  in  LEN_WIDTH  byte count.
  s_tdata_in  in  DATA_WIDTH  user payload.
  s_tvalid_in  in  1  payload valid.
  s_tlast_in  in  1  user end-of-transfer marker, checked only.
  s_tready_o  out  1  payload accepted.
  m_tdata_o  out  DATA_WIDTH  packet payload.
  m_tvalid_o  out  1  packet beat valid.
  m_tready_in  in  1  downstream (db_req) ready.
  m_tkeep_o  out  DATA_WIDTH/8  byte enables.
  m_tfirst_o  out  1  first beat of packet.
  m_tlast_o  out  1  last beat of packet.
  m_tsize_o  out  8  packet bytes minus 1.
  m_addr_o  out  ADDR_WIDTH  packet start address.
  m_done_o  out  1  beat is last of whole transfer.
  pkt_ack_in  in  1  nwr_done_ack pulse from db_req.
  len_err_o  out  1  one-cycle s_tlast mismatch pulse.
  pkt_cnt_o  out  16  packets completed since reset, wraps at 0xFFFF->0.

Function
REQ-006 SHALL implement states IDLE, HDR, DATA, WAIT_ACK.
REQ-007 IDLE: xfer_ready_o=1; on xfer_valid_in with xfer_len_in!=0, SHALL latch address and length and go to HDR; on xfer_len_in=0, SHALL take the handshake, stay in IDLE and emit no packet.
REQ-008 HDR, one cycle: SHALL set pkt_bytes=min(remaining, MAX_PKT_BYTES), register m_addr_o and m_tsize_o=pkt_bytes-1, then go to DATA; first m_tvalid_o can therefore occur 2 cycles after the xfer handshake.
REQ-009 DATA: m_tvalid_o=s_tvalid_in and s_tready_o=m_tready_in, combinational pass-through; a beat transfers when m_tvalid_o&&m_tready_in; outside DATA, s_tready_o=0 and m_tvalid_o=0.
REQ-010 m_tfirst_o SHALL be high on the first beat of each packet; m_tlast_o SHALL be high on beat ceil(pkt_bytes/(DATA_WIDTH/8)).
REQ-011 m_tkeep_o SHALL be all ones except on the final beat of the transfer, where the low (len mod bytes-per-beat) bits are set (all ones if that value is 0); s_tkeep is not an input.
REQ-012 m_done_o SHALL equal m_tlast_o on the last packet of the transfer, else 0.
REQ-013 On the m_tlast_o transfer, SHALL subtract pkt_bytes from remaining, add pkt_bytes to the address (ADDR_WIDTH wrap), and go to WAIT_ACK.
REQ-014 WAIT_ACK: SHALL hold all outputs idle until pkt_ack_in=1, then increment pkt_cnt_o and go to HDR if remaining!=0, else IDLE; pkt_ack_in in any other state SHALL be ignored.
REQ-015 len_err_o SHALL pulse for one cycle when s_tlast_in=1 on a transferred beat that is not the transfer's final beat, or s_tlast_in=0 on the final beat; segmentation SHALL continue by internal count regardless.
REQ-016 m_tvalid_o, m_tfirst_o, m_tlast_o and m_tkeep_o SHALL be stable while m_tvalid_o=1 and m_tready_in=0.

Reset
REQ-017 While log_rst=1 the block SHALL be in IDLE with all outputs 0, including xfer_ready_o, pkt_cnt_o and m_addr_o.
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer with no further beats; xfer_ready_o=1 on the first cycle after log_rst deasserts.

Verification (DATA_WIDTH=64, MAX_PKT_BYTES=256)
REQ-019 len=64, addr=0x1000, ready=1 -> 1 packet: 8 beats, m_tsize_o=63, m_addr_o=0x1000, keep 0xFF, m_done_o on beat 8.
REQ-020 len=596, addr=0x2000 -> 3 packets at 0x2000/0x2100/0x2200, sizes 255/255/83, beats 32/32/11, last keep 0x0F, pkt_cnt_o=3.
REQ-021 m_tready_in toggling 1010... -> payload order intact, s_tready_o mirrors m_tready_in, no duplicate or dropped beats.
REQ-022 pkt_ack_in delayed 20 cycles -> no m_tvalid_o and no HDR between packets until the ack; an ack while in DATA is ignored.
REQ-023 s_tlast_in on beat 3 of a 64-byte transfer -> len_err_o pulses once and 8 beats are still emitted; zero-length request -> no packet.
REQ-024 log_rst pulsed during beat 5 of packet 1 -> outputs 0, pkt_cnt_o=0, new 64-byte transfer completes normally.

Source files
------------

// File: rtl/nwr_segmenter.sv
// Splits a byte-addressed write transfer into RapidIO NWRITE packets of at most
// MAX_PKT_BYTES, passing user payload through and waiting for a per-packet ack.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a transfer request; zero-length requests are dropped
// HDR      | size the next packet, register its address and size
// DATA     | pass payload beats through until the packet's last beat
// WAIT_ACK | hold outputs idle until the downstream acknowledges the packet
module nwr_segmenter #(
    parameter int DATA_WIDTH    = 64,
    parameter int LEN_WIDTH     = 20,
    parameter int ADDR_WIDTH    = 34,
    parameter int MAX_PKT_BYTES = 256
) (
    input  logic                    log_clk,
    input  logic                    log_rst,
    input  logic                    xfer_valid_in,
    output logic                    xfer_ready_o,
    input  logic [ADDR_WIDTH-1:0]   xfer_addr_in,
    input  logic [LEN_WIDTH-1:0]    xfer_len_in,
    input  logic [DATA_WIDTH-1:0]   s_tdata_in,
    input  logic                    s_tvalid_in,
    input  logic                    s_tlast_in,
    output logic                    s_tready_o,
    output logic [DATA_WIDTH-1:0]   m_tdata_o,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_in,
    output logic [DATA_WIDTH/8-1:0] m_tkeep_o,
    output logic                    m_tfirst_o,
    output logic                    m_tlast_o,
    output logic [7:0]              m_tsize_o,
    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic                    m_done_o,
    input  logic                    pkt_ack_in,
    output logic                    len_err_o,
    output logic [15:0]             pkt_cnt_o
);

    localparam int BPB  = DATA_WIDTH / 8;
    localparam int SH   = $clog2(BPB);
    localparam int PB_W = $clog2(MAX_PKT_BYTES) + 1;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PKT_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_WAIT_ACK} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [SH-1:0]           tail_q, tail_d;
    logic [PB_W-1:0]         pkt_bytes_q, pkt_bytes_d;
    logic [PB_W-1:0]         beats_left_q, beats_left_d;
    logic                    first_q, first_d;
    logic                    last_pkt_q, last_pkt_d;
    logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
    logic [7:0]              m_tsize_q, m_tsize_d;
    logic [15:0]             pkt_cnt_q, pkt_cnt_d;
    logic                    len_err_q, len_err_d;

    logic                    in_data;
    logic                    beat_xfer;
    logic                    pkt_end;
    logic                    xfer_end;
    logic [PB_W-1:0]         pkt_bytes_hdr;
    logic [PB_W-1:0]         pkt_bytes_m1;
    logic [BPB-1:0]          keep_last;

    assign in_data       = (state_q == S_DATA) && !log_rst;
    assign beat_xfer     = in_data && s_tvalid_in && m_tready_in;
    assign pkt_end       = (beats_left_q == '0);
    assign xfer_end      = last_pkt_q && pkt_end;
    assign pkt_bytes_hdr = (rem_q >= MAX_LEN) ? PB_W'(MAX_PKT_BYTES) : rem_q[PB_W-1:0];
    assign pkt_bytes_m1  = pkt_bytes_hdr - PB_W'(1);

    // Only the transfer's final beat can be partial; a zero tail means a full beat.
    always_comb begin
        keep_last = '0;
        for (int i = 0; i < BPB; i++) begin
            keep_last[i] = (tail_q == '0) || (i < int'(tail_q));
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        tail_d       = tail_q;
        pkt_bytes_d  = pkt_bytes_q;
        beats_left_d = beats_left_q;
        first_d      = first_q;
        last_pkt_d   = last_pkt_q;
        m_addr_d     = m_addr_q;
        m_tsize_d    = m_tsize_q;
        pkt_cnt_d    = pkt_cnt_q;
        len_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xfer_valid_in && (xfer_len_in != '0)) begin
                    addr_d  = xfer_addr_in;
                    rem_d   = xfer_len_in;
                    tail_d  = xfer_len_in[SH-1:0];
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                pkt_bytes_d  = pkt_bytes_hdr;
                m_addr_d     = addr_q;
                m_tsize_d    = 8'(pkt_bytes_m1);
                beats_left_d = pkt_bytes_m1 >> SH;
                first_d      = 1'b1;
                last_pkt_d   = (rem_q <= MAX_LEN);
                state_d      = S_DATA;
            end
            S_DATA: begin
                if (beat_xfer) begin
                    first_d   = 1'b0;
                    len_err_d = (s_tlast_in != xfer_end);
                    if (pkt_end) begin
                        rem_d   = rem_q - LEN_WIDTH'(pkt_bytes_q);
                        addr_d  = addr_q + ADDR_WIDTH'(pkt_bytes_q);
                        state_d = S_WAIT_ACK;
                    end else begin
                        beats_left_d = beats_left_q - PB_W'(1);
                    end
                end
            end
            S_WAIT_ACK: begin
                if (pkt_ack_in) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    state_d   = (rem_q != '0) ? S_HDR : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            tail_q       <= '0;
            pkt_bytes_q  <= '0;
            beats_left_q <= '0;
            first_q      <= 1'b0;
            last_pkt_q   <= 1'b0;
            m_addr_q     <= '0;
            m_tsize_q    <= '0;
            pkt_cnt_q    <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            tail_q       <= tail_d;
            pkt_bytes_q  <= pkt_bytes_d;
            beats_left_q <= beats_left_d;
            first_q      <= first_d;
            last_pkt_q   <= last_pkt_d;
            m_addr_q     <= m_addr_d;
            m_tsize_q    <= m_tsize_d;
            pkt_cnt_q    <= pkt_cnt_d;
            len_err_q    <= len_err_d;
        end
    end

    // Outputs are forced low for the whole reset cycle, not just after the first edge.
    assign xfer_ready_o = (state_q == S_IDLE) && !log_rst;
    assign s_tready_o   = in_data && m_tready_in;
    assign m_tvalid_o   = in_data && s_tvalid_in;
    assign m_tdata_o    = in_data ? s_tdata_in : '0;
    assign m_tfirst_o   = in_data && first_q;
    assign m_tlast_o    = in_data && pkt_end;
    assign m_done_o     = in_data && xfer_end;
    assign m_tkeep_o    = !in_data ? '0 : (xfer_end ? keep_last : '1);
    assign m_tsize_o    = log_rst ? '0 : m_tsize_q;
    assign m_addr_o     = log_rst ? '0 : m_addr_q;
    assign pkt_cnt_o    = log_rst ? '0 : pkt_cnt_q;
    assign len_err_o    = len_err_q && !log_rst;

endmodule

// File: tb/tb_nwr_segmenter.sv
// Directed bench for nwr_segmenter (64-bit data, 256-byte packets): a payload
// source / sink / ack responder runs in the background, tests check its records.
module tb_nwr_segmenter;

    logic        log_clk = 1'b0;
    logic        log_rst;
    logic        xfer_valid_in;
    logic        xfer_ready_o;
    logic [33:0] xfer_addr_in;
    logic [19:0] xfer_len_in;
    logic [63:0] s_tdata_in;
    logic        s_tvalid_in;
    logic        s_tlast_in;
    logic        s_tready_o;
    logic [63:0] m_tdata_o;
    logic        m_tvalid_o;
    logic        m_tready_in;
    logic [7:0]  m_tkeep_o;
    logic        m_tfirst_o;
    logic        m_tlast_o;
    logic [7:0]  m_tsize_o;
    logic [33:0] m_addr_o;
    logic        m_done_o;
    logic        pkt_ack_in;
    logic        len_err_o;
    logic [15:0] pkt_cnt_o;

    nwr_segmenter #(
        .DATA_WIDTH(64), .LEN_WIDTH(20), .ADDR_WIDTH(34), .MAX_PKT_BYTES(256)
    ) dut (
        .log_clk(log_clk), .log_rst(log_rst),
        .xfer_valid_in(xfer_valid_in), .xfer_ready_o(xfer_ready_o),
        .xfer_addr_in(xfer_addr_in), .xfer_len_in(xfer_len_in),
        .s_tdata_in(s_tdata_in), .s_tvalid_in(s_tvalid_in), .s_tlast_in(s_tlast_in),
        .s_tready_o(s_tready_o),
        .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_in(m_tready_in),
        .m_tkeep_o(m_tkeep_o), .m_tfirst_o(m_tfirst_o), .m_tlast_o(m_tlast_o),
        .m_tsize_o(m_tsize_o), .m_addr_o(m_addr_o), .m_done_o(m_done_o),
        .pkt_ack_in(pkt_ack_in), .len_err_o(len_err_o), .pkt_cnt_o(pkt_cnt_o)
    );

    always #5 log_clk = ~log_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Background source / sink state
    logic [31:0] src_idx = 0;
    logic [31:0] exp_data = 0;
    logic [31:0] tlast_at = 32'hFFFF_FFFF;
    logic [31:0] tlast_bad = 32'hFFFF_FFFF;
    bit          ready_toggle = 0;
    int          ack_delay = 0;
    bit          stray_ack_en = 0;
    bit          stray_done = 0;
    bit          stray_pend = 0;
    bit          ack_active = 0;
    int          ack_timer = 0;
    logic [33:0] wait_addr = '0;

    int          pkt_n, total_beats, beats_in_pkt, done_cnt, done_beat;
    int          err_pulses, seq_err, mirror_err, stab_err, keep_err, wait_viol;
    logic [7:0]  last_keep;
    logic [33:0] rec_addr [8];
    logic [7:0]  rec_size [8];
    int          rec_beats [8];
    logic        lat_hdr, lat_data;

    task automatic clear_stats();
        pkt_n = 0; total_beats = 0; beats_in_pkt = 0; done_cnt = 0; done_beat = 0;
        err_pulses = 0; seq_err = 0; mirror_err = 0; stab_err = 0; keep_err = 0;
        wait_viol = 0; last_keep = '0;
        for (int i = 0; i < 8; i++) begin
            rec_addr[i] = '0; rec_size[i] = '0; rec_beats[i] = 0;
        end
    endtask

    initial begin
        bit          fire, adv, prev_stall;
        logic [10:0] prev_ctl;
        prev_stall = 0; prev_ctl = '0;
        clear_stats();
        m_tready_in = 1; s_tvalid_in = 1; pkt_ack_in = 0;
        s_tdata_in = {32'h5A5A_0000, src_idx}; s_tlast_in = 0;
        forever begin
            @(negedge log_clk);
            fire = m_tvalid_o && m_tready_in;
            adv  = s_tvalid_in && s_tready_o;
            if (m_tvalid_o && (s_tready_o !== m_tready_in)) mirror_err++;
            if (prev_stall && ({m_tvalid_o, m_tfirst_o, m_tlast_o, m_tkeep_o} !== prev_ctl)) stab_err++;
            prev_stall = m_tvalid_o && !m_tready_in;
            prev_ctl   = {m_tvalid_o, m_tfirst_o, m_tlast_o, m_tkeep_o};
            if (len_err_o) err_pulses++;
            if (ack_active && (m_tvalid_o || m_addr_o !== wait_addr || xfer_ready_o)) wait_viol++;
            if (fire) begin
                if (m_tfirst_o) begin
                    if (pkt_n < 8) begin
                        rec_addr[pkt_n] = m_addr_o;
                        rec_size[pkt_n] = m_tsize_o;
                    end
                    pkt_n++;
                    beats_in_pkt = 0;
                    if (stray_ack_en && !stray_done) stray_pend = 1;
                end
                beats_in_pkt++;
                total_beats++;
                if (m_tdata_o[31:0] !== exp_data) seq_err++;
                exp_data++;
                last_keep = m_tkeep_o;
                if (!m_done_o && m_tkeep_o !== 8'hFF) keep_err++;
                if (m_done_o) begin
                    done_cnt++;
                    done_beat = total_beats;
                end
                if (m_tlast_o) begin
                    if (pkt_n > 0 && pkt_n <= 8) rec_beats[pkt_n-1] = beats_in_pkt;
                    ack_active = 1;
                    ack_timer  = ack_delay;
                    wait_addr  = m_addr_o;
                end
            end
            @(posedge log_clk);
            #1;
            if (adv) src_idx++;
            s_tdata_in = {32'h5A5A_0000, src_idx};
            s_tlast_in = (src_idx == tlast_at) || (src_idx == tlast_bad);
            pkt_ack_in = 0;
            if (stray_pend) begin
                pkt_ack_in = 1; stray_pend = 0; stray_done = 1;
            end else if (ack_active) begin
                if (ack_timer == 0) begin
                    pkt_ack_in = 1; ack_active = 0;
                end else begin
                    ack_timer--;
                end
            end
            m_tready_in = ready_toggle ? !m_tready_in : 1'b1;
        end
    end

    // bad_beat: 1-based beat index that additionally carries s_tlast, 0 for none
    task automatic run_xfer(input logic [33:0] a, input logic [19:0] l, input bit tog,
                            input int dly, input bit stray, input int bad_beat);
        int cyc;
        clear_stats();
        ready_toggle = tog; ack_delay = dly; stray_ack_en = stray; stray_done = 0;
        tlast_at  = src_idx + 32'((l + 7) / 8) - 1;
        tlast_bad = (bad_beat > 0) ? src_idx + 32'(bad_beat) - 1 : 32'hFFFF_FFFF;
        xfer_addr_in = a; xfer_len_in = l; xfer_valid_in = 1;
        @(posedge log_clk); #2;
        xfer_valid_in = 0;
        lat_hdr = m_tvalid_o;
        @(posedge log_clk); #2;
        lat_data = m_tvalid_o;
        cyc = 0;
        while (!(xfer_ready_o && !ack_active) && cyc < 3000) begin
            @(posedge log_clk); #2;
            cyc++;
        end
        if (cyc >= 3000) check_val("xfer_timeout", 64'(cyc), 0);
        repeat (2) @(posedge log_clk);
        #2;
    endtask

    logic [15:0] cnt0;

    initial begin
        log_rst = 1; xfer_valid_in = 0; xfer_addr_in = '0; xfer_len_in = '0;
        repeat (3) @(posedge log_clk);
        @(negedge log_clk);
        check_val("rst_xfer_ready", xfer_ready_o, 0);
        check_val("rst_pkt_cnt", pkt_cnt_o, 0);
        check_val("rst_m_tvalid", m_tvalid_o, 0);
        check_val("rst_m_addr", m_addr_o, 0);
        @(posedge log_clk); #2;
        log_rst = 0;
        @(negedge log_clk);
        check_val("post_rst_ready", xfer_ready_o, 1);

        // 64 bytes at 0x1000: one 8-beat packet
        run_xfer(34'h1000, 20'd64, 0, 0, 0, 0);
        check_val("t1_lat_hdr", lat_hdr, 0);
        check_val("t1_lat_data", lat_data, 1);
        check_val("t1_pkts", pkt_n, 1);
        check_val("t1_beats", rec_beats[0], 8);
        check_val("t1_size", rec_size[0], 63);
        check_val("t1_addr", rec_addr[0], 34'h1000);
        check_val("t1_last_keep", last_keep, 8'hFF);
        check_val("t1_done_beat", done_beat, 8);
        check_val("t1_done_cnt", done_cnt, 1);
        check_val("t1_len_err", err_pulses, 0);
        check_val("t1_seq", seq_err, 0);
        check_val("t1_pkt_cnt", pkt_cnt_o, 1);

        // 596 bytes at 0x2000: 256 + 256 + 84
        cnt0 = pkt_cnt_o;
        run_xfer(34'h2000, 20'd596, 0, 0, 0, 0);
        check_val("t2_pkts", pkt_n, 3);
        check_val("t2_addr0", rec_addr[0], 34'h2000);
        check_val("t2_addr1", rec_addr[1], 34'h2100);
        check_val("t2_addr2", rec_addr[2], 34'h2200);
        check_val("t2_size0", rec_size[0], 255);
        check_val("t2_size1", rec_size[1], 255);
        check_val("t2_size2", rec_size[2], 83);
        check_val("t2_beats0", rec_beats[0], 32);
        check_val("t2_beats1", rec_beats[1], 32);
        check_val("t2_beats2", rec_beats[2], 11);
        check_val("t2_last_keep", last_keep, 8'h0F);
        check_val("t2_keep_mid", keep_err, 0);
        check_val("t2_done_beat", done_beat, 75);
        check_val("t2_cnt_delta", 16'(pkt_cnt_o - cnt0), 3);
        check_val("t2_len_err", err_pulses, 0);

        // 100 bytes at 0x3000 with m_tready toggling every cycle
        run_xfer(34'h3000, 20'd100, 1, 0, 0, 0);
        check_val("t3_beats", total_beats, 13);
        check_val("t3_size", rec_size[0], 99);
        check_val("t3_last_keep", last_keep, 8'h0F);
        check_val("t3_seq", seq_err, 0);
        check_val("t3_mirror", mirror_err, 0);
        check_val("t3_stable", stab_err, 0);
        check_val("t3_len_err", err_pulses, 0);

        // 512 bytes, ack delayed 20 cycles, stray ack during DATA
        cnt0 = pkt_cnt_o;
        run_xfer(34'h4000, 20'd512, 0, 20, 1, 0);
        check_val("t4_pkts", pkt_n, 2);
        check_val("t4_addr1", rec_addr[1], 34'h4100);
        check_val("t4_beats1", rec_beats[1], 32);
        check_val("t4_wait_idle", wait_viol, 0);
        check_val("t4_stray_sent", stray_done, 1);
        check_val("t4_cnt_delta", 16'(pkt_cnt_o - cnt0), 2);
        check_val("t4_last_keep", last_keep, 8'hFF);

        // early s_tlast on beat 3 (final beat also flagged): exactly one error pulse
        run_xfer(34'h5000, 20'd64, 0, 0, 0, 3);
        check_val("t5_len_err", err_pulses, 1);
        check_val("t5_beats", total_beats, 8);
        check_val("t5_seq", seq_err, 0);

        // zero-length request: handshake taken, no packet
        cnt0 = pkt_cnt_o;
        run_xfer(34'h6000, 20'd0, 0, 0, 0, 0);
        repeat (20) @(posedge log_clk);
        #2;
        check_val("t6_beats", total_beats, 0);
        check_val("t6_ready", xfer_ready_o, 1);
        check_val("t6_cnt", pkt_cnt_o, cnt0);

        // reset during beat 5 of a 64-byte transfer, then a clean transfer
        clear_stats();
        ready_toggle = 0; ack_delay = 0; stray_ack_en = 0;
        tlast_at = src_idx + 7; tlast_bad = 32'hFFFF_FFFF;
        xfer_addr_in = 34'h7000; xfer_len_in = 20'd64; xfer_valid_in = 1;
        @(posedge log_clk); #2;
        xfer_valid_in = 0;
        for (int c = 0; c < 50 && total_beats < 4; c++) begin
            @(posedge log_clk); #2;
        end
        check_val("t7_beats_before", total_beats, 4);
        log_rst = 1;
        @(negedge log_clk);
        check_val("t7_rst_tvalid", m_tvalid_o, 0);
        check_val("t7_rst_ready", xfer_ready_o, 0);
        check_val("t7_rst_cnt", pkt_cnt_o, 0);
        check_val("t7_rst_addr", m_addr_o, 0);
        check_val("t7_rst_sready", s_tready_o, 0);
        repeat (2) @(posedge log_clk);
        #2;
        log_rst = 0;
        @(negedge log_clk);
        check_val("t7_ready_after", xfer_ready_o, 1);
        check_val("t7_abandoned", total_beats, 4);
        run_xfer(34'h8000, 20'd64, 0, 0, 0, 0);
        check_val("t7_new_beats", total_beats, 8);
        check_val("t7_new_addr", rec_addr[0], 34'h8000);
        check_val("t7_new_done", done_beat, 8);
        check_val("t7_new_cnt", pkt_cnt_o, 1);
        check_val("t7_seq", seq_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
